hazard_scoreboard_ctrl: RTL

Parametrised successor to the pipeline's hazard detection unit. It replaces pure combinational EX/MEM Rd compares with a per-register countdown scoreboard. This supports variable producer latency (ALU, load, multi-cycle mul/div), WAW protection, fence drain and a multi-cycle front-end flush after a redirect. It sits beside the ID stage, drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush.

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/hazard_sb_regs.sv | 57 +++++
 rtl/hazard_scoreboard_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard controller.
// Provides the producer-class encoding, the class-to-latency mapping and
// the scoreboard counter width derivation used by the top and its register file.
package hazard_pkg;

  // Producer class as decoded in ID. NONE means the instruction produces
  // nothing that the scoreboard needs to track.
  typedef enum logic [1:0] {
    ALU    = 2'd0,
    LOAD   = 2'd1,
    MULDIV = 2'd2,
    NONE   = 2'd3
  } prod_class_e;

  // Cycles until a freshly issued producer's result can reach the ID
  // comparator. A value of 1 means "forwardable next cycle to EX", which a
  // non-branch consumer can tolerate but a branch (compared in ID) cannot.
  function automatic int unsigned class_lat(input logic [1:0] cls,
                                            input int unsigned muldiv_lat);
    case (cls)
      ALU:     class_lat = 1;
      LOAD:    class_lat = 2;
      MULDIV:  class_lat = muldiv_lat + 1;
      default: class_lat = 0;
    endcase
  endfunction

  // Counter must hold the largest load value, MULDIV_LAT+1.
  function automatic int unsigned cnt_width(input int unsigned muldiv_lat);
    cnt_width = $clog2(muldiv_lat + 2);
  endfunction

endpackage

// File: rtl/hazard_sb_regs.sv
// Per-register countdown scoreboard.
// Ports: one load port (load_en/load_addr/load_val), three combinational
// read ports (a/b for sources, c for destination) and busy = any counter nonzero.
module hazard_sb_regs
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [REG_ADDR_W-1:0] load_addr,
  input  logic [CNT_W-1:0]      load_val,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  input  logic [REG_ADDR_W-1:0] rd_addr_c,
  output logic [CNT_W-1:0]      rd_cnt_a,
  output logic [CNT_W-1:0]      rd_cnt_b,
  output logic [CNT_W-1:0]      rd_cnt_c,
  output logic                  busy
);

  localparam int NREG = 2 ** REG_ADDR_W;

  logic [CNT_W-1:0] cnt [NREG];

  // Entry 0 is only ever reset, so it reads as zero forever (x0 is hardwired).
  // A load on an entry wins over that entry's decrement in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (load_en && (load_addr == REG_ADDR_W'(r))) begin
          cnt[r] <= load_val;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  assign rd_cnt_a = cnt[rd_addr_a];
  assign rd_cnt_b = cnt[rd_addr_b];
  assign rd_cnt_c = cnt[rd_addr_c];

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      busy = busy | (cnt[r] != '0);
    end
  end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Hazard controller for the ID stage: countdown scoreboard for RAW/WAW,
// fence drain and a multi-cycle IF/ID flush after a redirect.
// Ports: ID decode info in; pc_write/ifid_write/stall/ifid_flush/id_issue/sb_busy out.
// Optional macro HAZARD_PERF_EN adds 32-bit saturating perf counters
// perf_raw_stalls, perf_waw_fence_stalls, perf_flushes.
module hazard_scoreboard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MULDIV_LAT  = 4,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic [1:0]            id_class,
  input  logic                  id_is_branch,
  input  logic                  id_is_fence,
  input  logic                  pc_src,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  stall,
  output logic                  ifid_flush,
  output logic                  id_issue,
  output logic                  sb_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_raw_stalls,
  output logic [31:0]           perf_waw_fence_stalls,
  output logic [31:0]           perf_flushes
`endif
);

  localparam int CNT_W   = cnt_width(MULDIV_LAT);
  localparam int FLUSH_W = $clog2(FLUSH_DEPTH + 1);

  logic [CNT_W-1:0]   rs1_cnt;
  logic [CNT_W-1:0]   rs2_cnt;
  logic [CNT_W-1:0]   rd_cnt;
  logic [CNT_W-1:0]   new_lat;
  logic [FLUSH_W-1:0] flush_cnt;
  logic               id_eff;
  logic               rd_tracked;
  logic               raw_rs1;
  logic               raw_rs2;
  logic               raw_haz;
  logic               waw_haz;
  logic               fence_haz;
  logic               sb_load;

  hazard_sb_regs #(
    .REG_ADDR_W (REG_ADDR_W),
    .CNT_W      (CNT_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .load_en   (sb_load),
    .load_addr (id_rd),
    .load_val  (new_lat),
    .rd_addr_a (id_rs1),
    .rd_addr_b (id_rs2),
    .rd_addr_c (id_rd),
    .rd_cnt_a  (rs1_cnt),
    .rd_cnt_b  (rs2_cnt),
    .rd_cnt_c  (rd_cnt),
    .busy      (sb_busy)
  );

  assign new_lat = CNT_W'(class_lat(id_class, MULDIV_LAT));

  // The instruction in ID is already doomed while a flush window is open,
  // so it can neither stall nor issue. The redirecting cycle itself (pc_src
  // with flush_cnt==0) still lets the branch issue.
  assign id_eff     = id_valid && (flush_cnt == '0);
  assign rd_tracked = id_reg_write && (id_rd != '0);

  // Non-branch consumers get EX forwarding, so a count of 1 is fine for them;
  // branches compare in ID and need the value fully available.
  assign raw_rs1 = id_uses_rs1 &&
                   (id_is_branch ? (rs1_cnt != '0) : (rs1_cnt > CNT_W'(1)));
  assign raw_rs2 = id_uses_rs2 &&
                   (id_is_branch ? (rs2_cnt != '0) : (rs2_cnt > CNT_W'(1)));
  assign raw_haz = raw_rs1 || raw_rs2;

  // A faster producer must not overtake a slower older one to the same rd.
  assign waw_haz   = rd_tracked && (rd_cnt > new_lat);
  assign fence_haz = id_is_fence && sb_busy;

  assign stall      = id_eff && (raw_haz || waw_haz || fence_haz);
  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign id_issue   = id_eff && !stall;
  assign ifid_flush = pc_src || (flush_cnt != '0);

  assign sb_load = id_issue && rd_tracked && (id_class != NONE);

  // flush_cnt counts the extra flush cycles after the redirect cycle; a new
  // redirect restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (pc_src) begin
      flush_cnt <= FLUSH_W'(FLUSH_DEPTH - 1);
    end else if (flush_cnt != '0) begin
      flush_cnt <= flush_cnt - FLUSH_W'(1);
    end
  end

`ifdef HAZARD_PERF_EN
  logic raw_hit;
  logic wf_hit;

  // A cycle with both a RAW and a WAW/fence cause is attributed to RAW only.
  assign raw_hit = id_eff && raw_haz;
  assign wf_hit  = id_eff && !raw_haz && (waw_haz || fence_haz);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_raw_stalls       <= '0;
      perf_waw_fence_stalls <= '0;
      perf_flushes          <= '0;
    end else begin
      if (raw_hit && (perf_raw_stalls != '1)) begin
        perf_raw_stalls <= perf_raw_stalls + 32'd1;
      end
      if (wf_hit && (perf_waw_fence_stalls != '1)) begin
        perf_waw_fence_stalls <= perf_waw_fence_stalls + 32'd1;
      end
      if (pc_src && (perf_flushes != '1)) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule
